// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port, the external port and the data-memory port of dmem_arbiter.
// Handshake: a requester raises *Req with stable Wr/Addr/WData and holds them until
// granted (coreStall low / extGnt high); a read answers with a one-cycle *RValid pulse
// in the cycle after its grant, writes never answer.
interface dmem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          coreReq;
  logic          coreWr;
  logic [AW-1:0] coreAddr;
  logic [DW-1:0] coreWData;
  logic          coreStall;
  logic [DW-1:0] coreRData;
  logic          coreRValid;

  logic          extReq;
  logic          extWr;
  logic [AW-1:0] extAddr;
  logic [DW-1:0] extWData;
  logic          extGnt;
  logic [DW-1:0] extRData;
  logic          extRValid;

  logic          memR;
  logic          memW;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWData;
  logic [DW-1:0] memRData;

  modport slave (
    input  coreReq, coreWr, coreAddr, coreWData,
    input  extReq, extWr, extAddr, extWData,
    input  memRData,
    output coreStall, coreRData, coreRValid,
    output extGnt, extRData, extRValid,
    output memR, memW, memAddr, memWData
  );

  modport master (
    output coreReq, coreWr, coreAddr, coreWData,
    output extReq, extWr, extAddr, extWData,
    output memRData,
    input  coreStall, coreRData, coreRValid,
    input  extGnt, extRData, extRValid,
    input  memR, memW, memAddr, memWData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core has fixed priority, bounded by a starvation
// counter that forces the external port through; read data returns one cycle later.
module dmem_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int MAXSTARVE = 4
) (
  input  logic                clk,
  input  logic                rst,
  dmem_arbiter_if.slave       bus,
  output logic [3:0]          dbg_starve_cnt_o,
  output logic [1:0]          dbg_rd_owner_o
);
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  localparam logic [3:0] STARVE_MAX = 4'(MAXSTARVE);

  logic [3:0]    starve_q, starve_d;
  owner_e        rd_owner_q, rd_owner_d;
  logic [DW-1:0] core_rdata_q, ext_rdata_q;

  logic          ext_force;
  logic          grant_core;
  logic          grant_ext;
  logic          grant_wr;
  logic [AW-1:0] mem_addr;
  logic          core_rvalid;
  logic          ext_rvalid;

  always_comb begin
    ext_force  = bus.extReq && (starve_q == STARVE_MAX);
    grant_ext  = ext_force || (bus.extReq && !bus.coreReq);
    grant_core = bus.coreReq && !ext_force;
    grant_wr   = grant_ext ? bus.extWr : bus.coreWr;
    mem_addr   = grant_ext ? bus.extAddr : bus.coreAddr;

    bus.memAddr   = mem_addr;
    bus.memWData  = grant_ext ? bus.extWData : bus.coreWData;
    // Grants still show during reset, but no access may reach the memory.
    bus.memR      = !rst && (grant_core || grant_ext) && !grant_wr;
    bus.memW      = !rst && (grant_core || grant_ext) && grant_wr;
    bus.coreStall = bus.coreReq && !grant_core;
    bus.extGnt    = grant_ext;
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.extReq || grant_ext) begin
      starve_d = '0;
    end else if (grant_core && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end

    rd_owner_d = OWN_NONE;
    if (grant_ext && !bus.extWr) begin
      rd_owner_d = OWN_EXT;
    end else if (grant_core && !bus.coreWr) begin
      rd_owner_d = OWN_CORE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q   <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // The memory's registered read data is forwarded in the return cycle and captured
  // so that RData keeps its last value while RValid is low.
  always_comb begin
    core_rvalid    = !rst && (rd_owner_q == OWN_CORE);
    ext_rvalid     = !rst && (rd_owner_q == OWN_EXT);
    bus.coreRValid = core_rvalid;
    bus.extRValid  = ext_rvalid;
    bus.coreRData  = core_rvalid ? bus.memRData : core_rdata_q;
    bus.extRData   = ext_rvalid ? bus.memRData : ext_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      if (core_rvalid) core_rdata_q <= bus.memRData;
      if (ext_rvalid)  ext_rdata_q  <= bus.memRData;
    end
  end

  assign dbg_starve_cnt_o = starve_q;
  assign dbg_rd_owner_o   = rd_owner_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios from the operating rules, then random
// traffic against a rule-level model with a shadow memory and expected-data queues.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MAXSTARVE = 4;
  localparam int DEPTH = 1 << AW;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic tb_init;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  logic [3:0] dbg_starve;
  logic [1:0] dbg_owner;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAXSTARVE(MAXSTARVE)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dbg_starve_cnt_o(dbg_starve), .dbg_rd_owner_o(dbg_owner)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    case (a)
      12'h010: return 32'hDEADBEEF;
      12'h001: return 32'hA5A50001;
      12'h002: return 32'h5A5A0002;
      default: return {a, 8'h3C, a} ^ 32'h13579BDF;
    endcase
  endfunction

  // memory attached to the DUT: synchronous read, data valid the cycle after memR
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i[AW-1:0]);
    end else begin
      if (bus.memW) ram[bus.memAddr] <= bus.memWData;
      if (bus.memR) bus.memRData <= ram[bus.memAddr];
    end
  end

  // scoreboard / reference model
  int            m_wait;      // cycles ext has been passed over in a row
  int            m_rv;        // port owed a read response this cycle: 0 none, 1 core, 2 ext
  int            m_last_win;  // port granted at the most recent edge
  logic [DW-1:0] shadow [0:DEPTH-1];
  logic [DW-1:0] m_core_hold, m_ext_hold;
  logic [DW-1:0] exp_core_q[$];
  logic [DW-1:0] exp_ext_q[$];

  function automatic int exp_winner();
    if (bus.extReq && m_wait >= MAXSTARVE) return 2;
    if (bus.coreReq) return 1;
    if (bus.extReq) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin : model_b
    int w;
    logic [AW-1:0] a;
    if (tb_init) for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i[AW-1:0]);
    w = exp_winner();
    m_last_win = w;
    if (rst) begin
      m_wait = 0; m_rv = 0; m_core_hold = '0; m_ext_hold = '0;
      exp_core_q.delete(); exp_ext_q.delete();
    end else begin
      if (m_rv == 1 && exp_core_q.size() > 0) m_core_hold = exp_core_q.pop_front();
      if (m_rv == 2 && exp_ext_q.size() > 0) m_ext_hold = exp_ext_q.pop_front();
      m_rv = 0;
      if (w == 1) begin
        a = bus.coreAddr;
        if (bus.coreWr) shadow[a] = bus.coreWData;
        else begin exp_core_q.push_back(shadow[a]); m_rv = 1; end
      end else if (w == 2) begin
        a = bus.extAddr;
        if (bus.extWr) shadow[a] = bus.extWData;
        else begin exp_ext_q.push_back(shadow[a]); m_rv = 2; end
      end
      m_wait = (w == 2 || !bus.extReq) ? 0 : m_wait + 1;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_core(input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.coreReq = req; bus.coreWr = wr; bus.coreAddr = a; bus.coreWData = d;
  endtask

  task automatic drive_ext(input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.extReq = req; bus.extWr = wr; bus.extAddr = a; bus.extWData = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_core(1'b1, 1'b0, 12'h010, '0);
    drive_ext(1'b1, 1'b0, 12'h0FF, '0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++; if (bus.memR !== 1'b0) begin n_errors++; $display("FAIL reset_memR: got %b exp 0", bus.memR); end
      n_checks++; if (bus.memW !== 1'b0) begin n_errors++; $display("FAIL reset_memW: got %b exp 0", bus.memW); end
      n_checks++; if (bus.coreRValid !== 1'b0 || bus.extRValid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got core %b ext %b exp 0 0", bus.coreRValid, bus.extRValid); end
      n_checks++; if (bus.coreRData !== '0 || bus.extRData !== '0) begin n_errors++; $display("FAIL reset_rdata: got core %h ext %h exp 0 0", bus.coreRData, bus.extRData); end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.coreStall !== 1'b0 || bus.extGnt !== 1'b0) begin n_errors++; $display("FAIL post_reset_grant: got stall %b extGnt %b exp 0 0", bus.coreStall, bus.extGnt); end
    n_checks++; if (bus.memR !== 1'b1 || bus.memAddr !== 12'h010) begin n_errors++; $display("FAIL post_reset_access: got memR %b addr %h exp 1 010", bus.memR, bus.memAddr); end
    tick();
    drive_core(1'b0, 1'b0, '0, '0);
    drive_ext(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_core_read();
    drive_core(1'b1, 1'b0, 12'h010, '0);
    @(negedge clk);
    n_checks++; if (bus.memR !== 1'b1 || bus.memW !== 1'b0 || bus.memAddr !== 12'h010) begin n_errors++; $display("FAIL core_read_issue: got memR %b memW %b addr %h exp 1 0 010", bus.memR, bus.memW, bus.memAddr); end
    n_checks++; if (bus.coreStall !== 1'b0) begin n_errors++; $display("FAIL core_read_stall: got %b exp 0", bus.coreStall); end
    tick();
    drive_core(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_checks++; if (bus.coreRValid !== 1'b1 || bus.coreRData !== 32'hDEADBEEF) begin n_errors++; $display("FAIL core_read_data: got v %b d %h exp 1 deadbeef", bus.coreRValid, bus.coreRData); end
    n_checks++; if (bus.extRValid !== 1'b0) begin n_errors++; $display("FAIL core_read_ext_quiet: got %b exp 0", bus.extRValid); end
    tick();
  endtask

  task automatic test_ext_write_read();
    drive_ext(1'b1, 1'b1, 12'h0FF, 32'h12345678);
    @(negedge clk);
    n_checks++; if (bus.extGnt !== 1'b1 || bus.memW !== 1'b1 || bus.memR !== 1'b0) begin n_errors++; $display("FAIL ext_write_issue: got gnt %b memW %b memR %b exp 1 1 0", bus.extGnt, bus.memW, bus.memR); end
    n_checks++; if (bus.memAddr !== 12'h0FF || bus.memWData !== 32'h12345678) begin n_errors++; $display("FAIL ext_write_bus: got addr %h data %h exp 0ff 12345678", bus.memAddr, bus.memWData); end
    tick();
    bus.extWr = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.extGnt !== 1'b1 || bus.memR !== 1'b1 || bus.memW !== 1'b0) begin n_errors++; $display("FAIL ext_read_issue: got gnt %b memR %b memW %b exp 1 1 0", bus.extGnt, bus.memR, bus.memW); end
    tick();
    drive_ext(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_checks++; if (bus.extRValid !== 1'b1 || bus.extRData !== 32'h12345678) begin n_errors++; $display("FAIL ext_read_data: got v %b d %h exp 1 12345678", bus.extRValid, bus.extRData); end
    n_checks++; if (bus.coreRValid !== 1'b0) begin n_errors++; $display("FAIL ext_read_core_quiet: got %b exp 0", bus.coreRValid); end
    tick();
  endtask

  task automatic test_starvation();
    logic prev_ext;
    drive_core(1'b1, 1'b0, 12'h001, '0);
    drive_ext(1'b1, 1'b0, 12'h002, '0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++; if (bus.extGnt !== (k % 5 == 0)) begin n_errors++; $display("FAIL starve_extgnt c%0d: got %b exp %b", k, bus.extGnt, (k % 5 == 0)); end
      n_checks++; if (bus.coreStall !== (k % 5 == 0)) begin n_errors++; $display("FAIL starve_stall c%0d: got %b exp %b", k, bus.coreStall, (k % 5 == 0)); end
      n_checks++; if (dbg_starve !== 4'((k - 1) % 5)) begin n_errors++; $display("FAIL starve_cnt c%0d: got %0d exp %0d", k, dbg_starve, (k - 1) % 5); end
      if (k >= 2) begin
        prev_ext = ((k - 1) % 5 == 0);
        n_checks++; if (bus.extRValid !== prev_ext || bus.coreRValid !== !prev_ext) begin n_errors++; $display("FAIL starve_rvalid c%0d: got core %b ext %b exp %b %b", k, bus.coreRValid, bus.extRValid, !prev_ext, prev_ext); end
        n_checks++; if (prev_ext ? (bus.extRData !== 32'h5A5A0002) : (bus.coreRData !== 32'hA5A50001)) begin n_errors++; $display("FAIL starve_rdata c%0d: got core %h ext %h", k, bus.coreRData, bus.extRData); end
      end
      tick();
    end
    drive_core(1'b0, 1'b0, '0, '0);
    drive_ext(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_reset_after_read();
    drive_core(1'b1, 1'b0, 12'h010, '0);
    @(negedge clk);
    n_checks++; if (bus.memR !== 1'b1) begin n_errors++; $display("FAIL rst_rd_issue: got memR %b exp 1", bus.memR); end
    tick();
    rst = 1'b1;
    drive_core(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_checks++; if (bus.coreRValid !== 1'b0 || bus.extRValid !== 1'b0) begin n_errors++; $display("FAIL rst_rd_suppress: got core %b ext %b exp 0 0", bus.coreRValid, bus.extRValid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (dbg_starve !== 4'd0 || dbg_owner !== 2'd0) begin n_errors++; $display("FAIL rst_rd_state: got cnt %0d owner %0d exp 0 0", dbg_starve, dbg_owner); end
    n_checks++; if (bus.coreRValid !== 1'b0 || bus.coreRData !== '0) begin n_errors++; $display("FAIL rst_rd_after: got v %b d %h exp 0 0", bus.coreRValid, bus.coreRData); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin drive_core(1'b1, 1'b0, 12'h001, '0); drive_ext(1'b0, 1'b0, '0, '0); end
      else begin drive_core(1'b0, 1'b0, '0, '0); drive_ext(1'b1, 1'b0, 12'h002, '0); end
      @(negedge clk);
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          n_checks++; if (bus.coreRValid !== 1'b1 || bus.extRValid !== 1'b0 || bus.coreRData !== 32'hA5A50001) begin n_errors++; $display("FAIL b2b_core c%0d: got cv %b ev %b d %h exp 1 0 a5a50001", i, bus.coreRValid, bus.extRValid, bus.coreRData); end
        end else begin
          n_checks++; if (bus.extRValid !== 1'b1 || bus.coreRValid !== 1'b0 || bus.extRData !== 32'h5A5A0002) begin n_errors++; $display("FAIL b2b_ext c%0d: got ev %b cv %b d %h exp 1 0 5a5a0002", i, bus.extRValid, bus.coreRValid, bus.extRData); end
          n_checks++; if (bus.coreRData !== 32'hA5A50001) begin n_errors++; $display("FAIL b2b_hold c%0d: got %h exp a5a50001", i, bus.coreRData); end
        end
      end
      tick();
    end
    drive_ext(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_checks++; if (bus.extRValid !== 1'b1 || bus.extRData !== 32'h5A5A0002) begin n_errors++; $display("FAIL b2b_last: got v %b d %h exp 1 5a5a0002", bus.extRValid, bus.extRData); end
    tick();
    // read then write of the same word: the read must see the old contents
    drive_core(1'b1, 1'b0, 12'h020, '0);
    tick();
    drive_core(1'b1, 1'b1, 12'h020, 32'hCAFEF00D);
    @(negedge clk);
    n_checks++; if (bus.coreRValid !== 1'b1 || bus.coreRData !== init_word(12'h020) || bus.memW !== 1'b1) begin n_errors++; $display("FAIL raw_old: got v %b d %h memW %b exp 1 %h 1", bus.coreRValid, bus.coreRData, bus.memW, init_word(12'h020)); end
    tick();
    drive_core(1'b1, 1'b0, 12'h020, '0);
    tick();
    drive_core(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_checks++; if (bus.coreRValid !== 1'b1 || bus.coreRData !== 32'hCAFEF00D) begin n_errors++; $display("FAIL raw_new: got v %b d %h exp 1 cafef00d", bus.coreRValid, bus.coreRData); end
    tick();
  endtask

  task automatic test_random();
    int w;
    logic e_any, e_wr, e_cv, e_ev;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_cd, e_ed;
    drive_core(1'b0, 1'b0, '0, '0);
    drive_ext(1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      w      = exp_winner();
      e_any  = (w != 0) && !rst;
      e_wr   = (w == 2) ? bus.extWr : bus.coreWr;
      e_addr = (w == 2) ? bus.extAddr : bus.coreAddr;
      e_wd   = (w == 2) ? bus.extWData : bus.coreWData;
      e_cv   = !rst && (m_rv == 1);
      e_ev   = !rst && (m_rv == 2);
      e_cd   = e_cv ? exp_core_q[0] : m_core_hold;
      e_ed   = e_ev ? exp_ext_q[0] : m_ext_hold;
      n_checks++; if (bus.memR !== (e_any && !e_wr) || bus.memW !== (e_any && e_wr)) begin n_errors++; $display("FAIL rnd_memrw c%0d: got r %b w %b exp %b %b", c, bus.memR, bus.memW, e_any && !e_wr, e_any && e_wr); end
      if (e_any) begin
        n_checks++; if (bus.memAddr !== e_addr) begin n_errors++; $display("FAIL rnd_addr c%0d: got %h exp %h", c, bus.memAddr, e_addr); end
      end
      if (e_any && e_wr) begin
        n_checks++; if (bus.memWData !== e_wd) begin n_errors++; $display("FAIL rnd_wdata c%0d: got %h exp %h", c, bus.memWData, e_wd); end
      end
      n_checks++; if (bus.coreStall !== (bus.coreReq && w != 1)) begin n_errors++; $display("FAIL rnd_stall c%0d: got %b exp %b", c, bus.coreStall, bus.coreReq && w != 1); end
      n_checks++; if (bus.extGnt !== (w == 2)) begin n_errors++; $display("FAIL rnd_extgnt c%0d: got %b exp %b", c, bus.extGnt, w == 2); end
      n_checks++; if (bus.coreRValid !== e_cv || bus.coreRData !== e_cd) begin n_errors++; $display("FAIL rnd_core_rd c%0d: got v %b d %h exp %b %h", c, bus.coreRValid, bus.coreRData, e_cv, e_cd); end
      n_checks++; if (bus.extRValid !== e_ev || bus.extRData !== e_ed) begin n_errors++; $display("FAIL rnd_ext_rd c%0d: got v %b d %h exp %b %h", c, bus.extRValid, bus.extRData, e_ev, e_ed); end
      tick();
      if (bus.coreReq && m_last_win == 1) bus.coreReq = 1'b0;
      if (bus.extReq && m_last_win == 2) bus.extReq = 1'b0;
      if (!bus.coreReq && $urandom_range(0, 9) < 6)
        drive_core(1'b1, $urandom_range(0, 2) == 0,
                   ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15)), $urandom);
      if (!bus.extReq && $urandom_range(0, 9) < 5)
        drive_ext(1'b1, $urandom_range(0, 1) == 0,
                  ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15)), $urandom);
      rst = ($urandom_range(0, 63) == 0);
    end
    rst = 1'b0;
    drive_core(1'b0, 1'b0, '0, '0);
    drive_ext(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    tb_init = 1'b1;
    drive_core(1'b0, 1'b0, '0, '0);
    drive_ext(1'b0, 1'b0, '0, '0);
    tick();
    tb_init = 1'b0;
    test_reset();
    test_core_read();
    test_ext_write_read();
    test_starvation();
    test_reset_after_read();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
